// File: rtl/vmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmem_pkg
// Brief    : Shared types and constants for the vector memory sequencer.
//            Optional feature macro used by the sequencer: VMEM_ALIGN_CHECK_EN
// Revision : 1.0 - initial release
// ============================================================================
package vmem_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } vmem_state_t;

    localparam int         VMEM_WORD_BYTES    = 4;
    localparam int         VMEM_VLEN_WORDS    = 4;
    localparam logic [1:0] VMEM_LAST_BEAT_VEC = 2'd3;

    // Index of the final beat: scalar accesses are a single beat 0
    function automatic logic [1:0] vmem_last_beat(input logic i_vec);
        return i_vec ? VMEM_LAST_BEAT_VEC : 2'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_lane_sel.sv
`default_nettype none
// ============================================================================
// Module   : vmem_lane_sel
// Brief    : 128->32 write-lane select and 32->128 read-lane merge, both
//            indexed by the current beat.
// Revision : 1.0 - initial release
// ============================================================================
module vmem_lane_sel
    import vmem_pkg::*;
(
    input  logic [127:0] i_lanes,
    input  logic [1:0]   i_beat,
    input  logic [31:0]  i_word,
    input  logic [127:0] i_cur,
    output logic [31:0]  o_lane,
    output logic [127:0] o_merged
);

    logic [6:0] w_base;
    assign w_base = {i_beat, 5'b00000};

    // Pick the write lane and overlay the returned word onto the current value
    always_comb begin
        o_lane   = i_lanes[w_base +: 32];
        o_merged = i_cur;
        o_merged[w_base +: 32] = i_word;
    end

endmodule
`default_nettype wire

// File: rtl/vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_mem_sequencer
// Brief    : Sequences MEM-stage scalar (1 beat) and 128-bit vector (4 beat)
//            loads/stores onto a 32-bit req/ack data memory port, holding the
//            pipeline via mem_stall until the access completes.
//            Optional macro: VMEM_ALIGN_CHECK_EN (misaligned request trap).
// Revision : 1.0 - initial release
// ============================================================================
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int VLEN_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_mem_read,
    input  logic              mem_mem_write,
    input  logic              mem_vector_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [127:0]      mem_write_data,
    output logic [127:0]      mem_read_data,
    output logic              mem_stall,
    output logic              mem_done,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              align_err
);

    vmem_state_t       r_state;
    logic              r_we;
    logic              r_vec;
    logic [ADDR_W-1:0] r_addr;
    logic [127:0]      r_wdata;
    logic [1:0]        r_beat;
    logic [127:0]      r_rdata;

    logic              w_req;
    logic              w_access;
    logic              w_last;
    logic [ADDR_W-1:0] w_beat_off;
    logic [31:0]       w_lane_wdata;
    logic [127:0]      w_merged;

    assign w_req      = mem_mem_read | mem_mem_write;
    assign w_access   = (r_state == ACCESS);
    assign w_last     = (r_beat == vmem_last_beat(r_vec));
    assign w_beat_off = ADDR_W'(r_beat) * ADDR_W'(VMEM_WORD_BYTES);

`ifdef VMEM_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_align_err;
    assign w_misaligned = mem_vector_op ? (mem_addr[3:0] != 4'd0)
                                        : (mem_addr[1:0] != 2'd0);
    assign align_err    = r_align_err;
`else
    assign align_err    = 1'b0;
`endif

    vmem_lane_sel u_lane_sel (
        .i_lanes  (r_wdata),
        .i_beat   (r_beat),
        .i_word   (dmem_rdata),
        .i_cur    (r_rdata),
        .o_lane   (w_lane_wdata),
        .o_merged (w_merged)
    );

    // Memory port is decoded purely from registered state; idle values are 0
    assign dmem_req   = w_access;
    assign dmem_we    = w_access & r_we;
    assign dmem_addr  = w_access ? (r_addr + w_beat_off) : '0;
    assign dmem_wdata = w_access ? w_lane_wdata : 32'd0;

    // Stall covers the request cycle in IDLE and every ACCESS cycle
    assign mem_stall     = reset & ((r_state == IDLE & w_req) | w_access);
    assign mem_done      = (r_state == DONE);
    assign mem_read_data = r_rdata;

    // FSM, beat counter, request latches and read-data assembly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_vec   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_beat  <= 2'd0;
            r_rdata <= '0;
`ifdef VMEM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // Write wins when both read and write are asserted
                        r_we    <= mem_mem_write;
                        r_vec   <= mem_vector_op;
                        r_addr  <= mem_addr;
                        r_wdata <= mem_write_data;
                        r_beat  <= 2'd0;
`ifdef VMEM_ALIGN_CHECK_EN
                        if (w_misaligned) begin
                            r_state     <= DONE;
                            r_align_err <= 1'b1;
                        end else begin
                            r_state <= ACCESS;
                        end
`else
                        r_state <= ACCESS;
`endif
                    end
                end
                ACCESS: begin
                    // Request held stable until ack; inputs are ignored here
                    if (dmem_ack) begin
                        if (!r_we) begin
                            r_rdata <= r_vec ? w_merged : {VLEN_WORDS{dmem_rdata}};
                        end
                        r_beat <= r_beat + 2'd1;
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
`ifdef VMEM_ALIGN_CHECK_EN
                    r_align_err <= 1'b0;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
